// File: rtl/lf_pkg.sv
// rtl/lf_pkg.sv - shared types and helpers for the line follower steering block
package lf_pkg;

  localparam int SPD_W     = 4;
  localparam int MAX_SPEED = 10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FWD    = 3'd1,
    ST_LEFT   = 3'd2,
    ST_RIGHT  = 3'd3,
    ST_SEARCH = 3'd4,
    ST_STOP   = 3'd5
  } state_t;

  typedef enum logic {
    TURN_L = 1'b0,
    TURN_R = 1'b1
  } turn_t;

  function automatic logic [SPD_W-1:0] clamp_speed(input int s);
    if (s > MAX_SPEED) return SPD_W'(MAX_SPEED);
    if (s < 0) return '0;
    return SPD_W'(s);
  endfunction

  function automatic logic is_active(input state_t s);
    return !(s == ST_IDLE || s == ST_STOP);
  endfunction

  // 101 has no meaning on the bar, so it leaves the state alone.
  function automatic state_t decode_pat(input logic [2:0] p, input state_t cur);
    case (p)
      3'b010, 3'b111: return ST_FWD;
      3'b110, 3'b100: return ST_LEFT;
      3'b011, 3'b001: return ST_RIGHT;
      3'b000:         return ST_SEARCH;
      default:        return cur;
    endcase
  endfunction

endpackage

// File: rtl/motor_ramp.sv
// rtl/motor_ramp.sv - per-wheel speed/direction ramp, one step per control tick
module motor_ramp
  import lf_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic [SPD_W-1:0] tgt_speed,
  input  logic             tgt_fwd,
  output logic [SPD_W-1:0] speed,
  output logic             fwd,
  output logic [SPD_W-1:0] speed_nxt
);

  localparam logic [SPD_W-1:0] ONE = SPD_W'(1);
  localparam logic [SPD_W-1:0] TOP = SPD_W'(MAX_SPEED);

  logic [SPD_W-1:0] tgt;
  logic             fwd_nxt;

  assign tgt = (tgt_speed > TOP) ? TOP : tgt_speed;

  // A direction change must first bleed the wheel down to a standstill.
  always_comb begin
    speed_nxt = speed;
    fwd_nxt   = fwd;
    if (tick) begin
      if (tgt_fwd != fwd) begin
        if (speed != '0) speed_nxt = speed - ONE;
        else             fwd_nxt   = tgt_fwd;
      end else if (speed < tgt) begin
        speed_nxt = speed + ONE;
      end else if (speed > tgt) begin
        speed_nxt = speed - ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      speed <= '0;
      fwd   <= 1'b1;
    end else begin
      speed <= speed_nxt;
      fwd   <= fwd_nxt;
    end
  end

endmodule

// File: rtl/line_follow_ctrl.sv
// rtl/line_follow_ctrl.sv - IR bar debounce, steering FSM and wheel ramps for the line follower
module line_follow_ctrl
  import lf_pkg::*;
#(
  parameter int TICK_DIV   = 100000,
  parameter int DEB_TICKS  = 3,
  parameter int CRUISE     = 8,
  parameter int SLOW       = 3,
  parameter int SEARCH_SPD = 4,
  parameter int LOST_TICKS = 2000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic [2:0] sensor,
  output logic       mLEN,
  output logic       mREN,
  output logic [3:0] mLspeed,
  output logic [3:0] mRspeed,
  output logic       mLfwd,
  output logic       mRfwd,
  output logic [2:0] state
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = $clog2(DEB_TICKS + 1);
  localparam int LW = (LOST_TICKS > 1) ? $clog2(LOST_TICKS) : 1;

  localparam logic [SPD_W-1:0] SPD_CRUISE = clamp_speed(CRUISE);
  localparam logic [SPD_W-1:0] SPD_SLOW   = clamp_speed(SLOW);
  localparam logic [SPD_W-1:0] SPD_SEARCH = clamp_speed(SEARCH_SPD);

  logic [TW-1:0]    tick_cnt;
  logic             tick;
  logic [2:0]       s_meta, s_sync;
  logic [2:0]       cand, pat, pat_nxt;
  logic [DW-1:0]    deb_cnt, deb_cnt_nxt;
  logic [LW-1:0]    lost_cnt;
  state_t           st, st_nxt;
  turn_t            last_turn;
  logic [SPD_W-1:0] l_tgt, r_tgt, l_speed_nxt, r_speed_nxt;
  logic             l_tgt_fwd, r_tgt_fwd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
      tick     <= 1'b0;
      s_meta   <= '0;
      s_sync   <= '0;
    end else begin
      tick     <= (tick_cnt == TW'(TICK_DIV - 1));
      tick_cnt <= (tick_cnt == TW'(TICK_DIV - 1)) ? '0 : tick_cnt + TW'(1);
      s_meta   <= sensor;
      s_sync   <= s_meta;
    end
  end

  // The FSM sees the pattern accepted on this very tick, not last tick's.
  always_comb begin
    deb_cnt_nxt = deb_cnt;
    pat_nxt     = pat;
    if (tick) begin
      if (s_sync == cand)
        deb_cnt_nxt = (deb_cnt == DW'(DEB_TICKS)) ? deb_cnt : deb_cnt + DW'(1);
      else
        deb_cnt_nxt = DW'(1);
      if (deb_cnt_nxt == DW'(DEB_TICKS) && s_sync != 3'b101)
        pat_nxt = s_sync;
    end
  end

  always_comb begin
    st_nxt = st;
    if (tick) begin
      if (!run) begin
        st_nxt = ST_IDLE;
      end else begin
        case (st)
          ST_IDLE: st_nxt = ST_FWD;
          ST_STOP: st_nxt = ST_STOP;
          default: begin
            if (st == ST_SEARCH && pat_nxt == 3'b000 && lost_cnt == LW'(LOST_TICKS - 1))
              st_nxt = ST_STOP;
            else
              st_nxt = decode_pat(pat_nxt, st);
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand      <= 3'b010;
      pat       <= 3'b010;
      deb_cnt   <= '0;
      lost_cnt  <= '0;
      st        <= ST_IDLE;
      last_turn <= TURN_L;
      mLEN      <= 1'b0;
      mREN      <= 1'b0;
    end else if (tick) begin
      cand    <= s_sync;
      pat     <= pat_nxt;
      deb_cnt <= deb_cnt_nxt;
      st      <= st_nxt;
      if (st != ST_SEARCH)
        lost_cnt <= '0;
      else if (lost_cnt != LW'(LOST_TICKS - 1))
        lost_cnt <= lost_cnt + LW'(1);
      if (st_nxt == ST_LEFT)  last_turn <= TURN_L;
      if (st_nxt == ST_RIGHT) last_turn <= TURN_R;
      mLEN <= is_active(st_nxt) || (l_speed_nxt != '0);
      mREN <= is_active(st_nxt) || (r_speed_nxt != '0);
    end
  end

  // Idle and stop aim for zero while keeping whatever direction the wheel has.
  always_comb begin
    l_tgt     = '0;
    r_tgt     = '0;
    l_tgt_fwd = mLfwd;
    r_tgt_fwd = mRfwd;
    case (st)
      ST_FWD: begin
        l_tgt = SPD_CRUISE; l_tgt_fwd = 1'b1;
        r_tgt = SPD_CRUISE; r_tgt_fwd = 1'b1;
      end
      ST_LEFT: begin
        l_tgt = SPD_SLOW;   l_tgt_fwd = 1'b1;
        r_tgt = SPD_CRUISE; r_tgt_fwd = 1'b1;
      end
      ST_RIGHT: begin
        l_tgt = SPD_CRUISE; l_tgt_fwd = 1'b1;
        r_tgt = SPD_SLOW;   r_tgt_fwd = 1'b1;
      end
      ST_SEARCH: begin
        l_tgt     = SPD_SEARCH;
        r_tgt     = SPD_SEARCH;
        l_tgt_fwd = (last_turn == TURN_R);
        r_tgt_fwd = (last_turn == TURN_L);
      end
      default: ;
    endcase
  end

  motor_ramp u_ramp_l (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick      (tick),
    .tgt_speed (l_tgt),
    .tgt_fwd   (l_tgt_fwd),
    .speed     (mLspeed),
    .fwd       (mLfwd),
    .speed_nxt (l_speed_nxt)
  );

  motor_ramp u_ramp_r (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick      (tick),
    .tgt_speed (r_tgt),
    .tgt_fwd   (r_tgt_fwd),
    .speed     (mRspeed),
    .fwd       (mRfwd),
    .speed_nxt (r_speed_nxt)
  );

  assign state = st;

endmodule

// File: doc/line_follow_ctrl.md
# line_follow_ctrl

Steering sequencer for the two-wheel line follower. It samples the 3-bit IR sensor bar on a slow tick, debounces it, and runs a steering FSM. It drives speed, direction and enable for the left and right `motor` PWM instances, ramping speed one step per tick. Direction is reversed only after the wheel's speed has ramped to 0.

## Interface
- `TICK_DIV`, 100000: clk cycles per control tick (1 ms at 100 MHz).
- `DEB_TICKS`, 3: consecutive identical samples needed to accept a sensor pattern.
- `CRUISE`, 8: straight-line speed (0..10).
- `SLOW`, 3: inner-wheel speed while turning.
- `SEARCH_SPD`, 4: pivot speed while searching.
- `LOST_TICKS`, 2000: ticks in SEARCH before STOP.
- `clk`  in  1  system clock; one clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `run`  in  1  level; 1 = follow the line, 0 = ramp down to idle.
- `sensor`  in  3  {left, centre, right}; 1 = line under sensor. Asynchronous; double-flop internally.
- `mLEN`, `mREN`  out  1  motor enables.
- `mLspeed`, `mRspeed`  out  4  speed 0..10 to the motor blocks.
- `mLfwd`, `mRfwd`  out  1  1 = forward, 0 = reverse.
- `state`  out  3  current FSM state, for LEDs/debug.

## Operation
- States: IDLE=0, FWD=1, LEFT=2, RIGHT=3, SEARCH=4, STOP=5.
- Accepted pattern `pat` updates when DEB_TICKS consecutive tick samples match. Pattern 101 is never accepted; `pat` holds its value.
- Transitions are evaluated on each tick, in priority order:
  - `run`=0 → IDLE from any state.
  - IDLE with `run`=1 → FWD.
  - Active states (FWD/LEFT/RIGHT/SEARCH): `pat` 010/111 → FWD; 110/100 → LEFT; 011/001 → RIGHT; 000 → SEARCH.
  - SEARCH with lost counter = LOST_TICKS−1 and `pat`=000 → STOP.
  - STOP exits only through `run`=0.
- `last_turn` is set to L on entry to LEFT and to R on entry to RIGHT. It resets to L.
- Targets as (speed, dir) per wheel:
  - FWD: L=(CRUISE,fwd), R=(CRUISE,fwd).
  - LEFT: L=(SLOW,fwd), R=(CRUISE,fwd).
  - RIGHT: mirror of LEFT.
  - SEARCH with `last_turn`=L: L=(SEARCH_SPD,rev), R=(SEARCH_SPD,fwd); mirrored for R.
  - IDLE/STOP: both (0, direction unchanged).
- Per-wheel ramp, once per tick:
  - target dir ≠ current dir and speed>0 → speed−1.
  - target dir ≠ current dir and speed=0 → flip dir; no speed change that tick.
  - otherwise speed moves ±1 toward the target speed.
  - Speed never exceeds 10; targets above 10 are clamped to 10.
- Enable: mXEN = 1 when state ∉ {IDLE, STOP} or mXspeed ≠ 0.
- Lost counter clears on any tick not in SEARCH and saturates at LOST_TICKS−1.

## Timing
- Reset values: state=IDLE, mLspeed=mRspeed=0, mLfwd=mRfwd=1, mLEN=mREN=0, `pat`=010, all counters 0.
- Tick is a one-cycle strobe when the tick counter wraps from TICK_DIV−1 to 0. The counter width is $clog2(TICK_DIV).
- Sensor path: 2-cycle synchroniser. Pattern acceptance occurs on the DEB_TICKS-th matching tick.
- FSM state registers on the tick where its condition is met. The ramp uses the new targets on the following tick, so speed first changes one tick after the state change.
- All outputs are registered and change only on the cycle after the tick strobe, except during reset.
- Reset asserted mid-ramp forces the reset values immediately (asynchronous). After release, the first tick occurs TICK_DIV cycles later.
- If `run` falls and `pat` changes on the same tick, `run` wins.

## Structure
- Package `lf_pkg`: state encoding, MAX_SPEED=10, speed width 4.
- Sub-module `motor_ramp`, instantiated twice (L, R):
  - inputs: tick, target speed, target dir;
  - outputs: speed, dir.
- The top level holds the synchroniser, tick divider, debouncer, FSM and lost counter.

## Test plan
Simulation parameters: TICK_DIV=4, DEB_TICKS=2, LOST_TICKS=8, CRUISE=8, SLOW=3, SEARCH_SPD=4.
- Reset, then `run`=1, `sensor`=010 → state 1 after 1 tick; speeds rise 1..8 over 8 ticks; EN=1; fwd=1.
- From cruise 8/8, `sensor`=110 held 2 ticks → state 2; L ramps 8→3 while R stays 8; a single-tick 110 glitch produces no state change.
- From LEFT, `sensor`=000 → SEARCH:
  - L ramps 3→0, flips mLfwd to 0 on the next tick, then rises to 4;
  - R ramps 8→4.
- SEARCH with 000 held 8 ticks → state 5; speeds ramp to 0; EN drops when speed hits 0. `run` toggled 0→1 → IDLE then FWD.
- `sensor`=101 at cruise → state and speeds unchanged.
- `rst_n` pulsed low mid-ramp → all outputs at reset values within the same cycle.
